ap_chain_lookup: RTL and testbench

- Parametrised successor to the atomic-predicate lookup stage; sits between the parser's AP FIFO and the output-port-lookup (opl) processor.
- For each AP pointer accepted, walks a linked chain in an on-chip AP table, one entry per cycle, merging each entry's action word into a result.
- Adds over the earlier block: selectable merge mode, hop-limit loop guard with error flag, valid/ready backpressure on both sides, hardware table clear after reset, direct table read/write port, and saturating statistics counters.

---
 rtl/ap_chain_lookup.sv | 167 ++++++++++++++++
 tb/tb_ap_chain_lookup.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_chain_lookup.sv
// Atomic-predicate chain walker: follows linked table entries from a head pointer and merges their action words.
// Latency N+1 cycles for an N-entry chain; ap_in_ready only in IDLE, and the result is held until result_ready.
module ap_chain_lookup #(
  parameter int AP_WIDTH     = 32,
  parameter int ACTION_WIDTH = 64,
  parameter int DEPTH        = 16,
  parameter int DEPTH_BITS   = $clog2(DEPTH),
  parameter int MAX_HOPS     = 8,
  parameter int HOP_BITS     = $clog2(MAX_HOPS) + 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [AP_WIDTH-1:0]              ap_in,
  input  logic                             ap_in_valid,
  output logic                             ap_in_ready,
  input  logic [1:0]                       merge_mode,
  output logic [ACTION_WIDTH-1:0]          result_action,
  output logic [HOP_BITS-1:0]              result_hops,
  output logic                             result_err,
  output logic                             result_valid,
  input  logic                             result_ready,
  input  logic                             tbl_wr_en,
  input  logic [DEPTH_BITS-1:0]            tbl_wr_addr,
  input  logic [AP_WIDTH+ACTION_WIDTH-1:0] tbl_wr_data,
  input  logic                             tbl_rd_en,
  input  logic [DEPTH_BITS-1:0]            tbl_rd_addr,
  output logic [AP_WIDTH+ACTION_WIDTH-1:0] tbl_rd_data,
  output logic                             tbl_rd_valid,
  output logic                             init_done,
  output logic [31:0]                      lookup_count,
  output logic [31:0]                      err_count
);
  localparam int ENTRY_W = AP_WIDTH + ACTION_WIDTH;
  localparam logic [1:0] MODE_LAST  = 2'd1;
  localparam logic [1:0] MODE_FIRST = 2'd2;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WALK, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ENTRY_W-1:0]      tbl_q [DEPTH];
  logic [DEPTH_BITS-1:0]   clr_cnt_q, ptr_addr_q;
  logic                    ptr_end_q, first_q, err_q, init_done_q, rd_valid_q;
  logic [1:0]              mode_q;
  logic [ACTION_WIDTH-1:0] acc_q, acc_d;
  logic [HOP_BITS-1:0]     hops_q, hops_d;
  logic                    first_d, walk_err, walk_done, clr_last, accept, res_hs;
  logic [ENTRY_W-1:0]      entry, rd_data_q;
  logic [AP_WIDTH-1:0]     e_next;
  logic [ACTION_WIDTH-1:0] e_action;
  logic [31:0]             lookup_cnt_q, err_cnt_q;

  // Pointer bits between the table index and the end flag carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ap_in[AP_WIDTH-2:DEPTH_BITS], e_next[AP_WIDTH-2:DEPTH_BITS]};

  assign clr_last = (clr_cnt_q == DEPTH_BITS'(DEPTH - 1));
  assign accept   = ap_in_valid && ap_in_ready;
  assign res_hs   = result_valid && result_ready;

  always_comb begin
    entry    = tbl_q[ptr_addr_q];
    e_next   = entry[ENTRY_W-1:ACTION_WIDTH];
    e_action = entry[ACTION_WIDTH-1:0];
    hops_d   = hops_q + HOP_BITS'(1);
    acc_d    = acc_q;
    first_d  = first_q;
    case (mode_q)
      MODE_LAST:  acc_d = e_action;
      MODE_FIRST: begin
        if (!first_q && (e_action != '0)) begin
          acc_d   = e_action;
          first_d = 1'b1;
        end
      end
      default:    acc_d = acc_q | e_action;
    endcase
    walk_err  = !ptr_end_q && (hops_d == HOP_BITS'(MAX_HOPS));
    walk_done = ptr_end_q || walk_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_CLEAR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_last)     state_d = S_IDLE;
      S_IDLE:  if (ap_in_valid)  state_d = S_WALK;
      S_WALK:  if (walk_done)    state_d = S_DONE;
      S_DONE:  if (result_ready) state_d = S_IDLE;
      default:                   state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    ap_in_ready  = (state_q == S_IDLE);
    result_valid = (state_q == S_DONE);
  end

  // The table has no reset; CLEAR owns the write port until every entry is initialised.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR)
      tbl_q[clr_cnt_q] <= {{AP_WIDTH{1'b1}}, {ACTION_WIDTH{1'b0}}};
    else if (tbl_wr_en)
      tbl_q[tbl_wr_addr] <= tbl_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_q    <= '0;
      init_done_q  <= 1'b0;
      ptr_addr_q   <= '0;
      ptr_end_q    <= 1'b0;
      mode_q       <= '0;
      acc_q        <= '0;
      hops_q       <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      lookup_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (state_q == S_CLEAR) begin
        clr_cnt_q <= clr_cnt_q + DEPTH_BITS'(1);
        if (clr_last) init_done_q <= 1'b1;
      end
      rd_valid_q <= tbl_rd_en && (state_q != S_CLEAR);
      if (tbl_rd_en && (state_q != S_CLEAR)) rd_data_q <= tbl_q[tbl_rd_addr];
      if (accept) begin
        ptr_addr_q <= ap_in[DEPTH_BITS-1:0];
        ptr_end_q  <= ap_in[AP_WIDTH-1];
        mode_q     <= merge_mode;
        acc_q      <= '0;
        hops_q     <= '0;
        first_q    <= 1'b0;
        err_q      <= 1'b0;
      end
      if (state_q == S_WALK) begin
        acc_q   <= acc_d;
        hops_q  <= hops_d;
        first_q <= first_d;
        if (walk_done) begin
          err_q <= walk_err;
        end else begin
          ptr_addr_q <= e_next[DEPTH_BITS-1:0];
          ptr_end_q  <= e_next[AP_WIDTH-1];
        end
      end
      if (res_hs) begin
        if (lookup_cnt_q != '1)           lookup_cnt_q <= lookup_cnt_q + 32'd1;
        if (err_q && (err_cnt_q != '1))   err_cnt_q    <= err_cnt_q + 32'd1;
      end
    end
  end

  assign result_action = acc_q;
  assign result_hops   = hops_q;
  assign result_err    = err_q;
  assign tbl_rd_data   = rd_data_q;
  assign tbl_rd_valid  = rd_valid_q;
  assign init_done     = init_done_q;
  assign lookup_count  = lookup_cnt_q;
  assign err_count     = err_cnt_q;
endmodule

// File: tb/tb_ap_chain_lookup.sv
// Bench for ap_chain_lookup: vector table of chain lookups plus hand sequences for
// clear timing, backpressure, write-during-walk, read/write collision and mid-walk reset.
module tb_ap_chain_lookup;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ap_in;
  logic        ap_in_valid, ap_in_ready;
  logic [1:0]  merge_mode;
  logic [63:0] result_action;
  logic [3:0]  result_hops;
  logic        result_err, result_valid, result_ready;
  logic        tbl_wr_en, tbl_rd_en;
  logic [3:0]  tbl_wr_addr, tbl_rd_addr;
  logic [95:0] tbl_wr_data, tbl_rd_data;
  logic        tbl_rd_valid, init_done;
  logic [31:0] lookup_count, err_count;

  ap_chain_lookup dut (
    .clk(clk), .reset_n(reset_n),
    .ap_in(ap_in), .ap_in_valid(ap_in_valid), .ap_in_ready(ap_in_ready),
    .merge_mode(merge_mode),
    .result_action(result_action), .result_hops(result_hops), .result_err(result_err),
    .result_valid(result_valid), .result_ready(result_ready),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
    .tbl_rd_valid(tbl_rd_valid), .init_done(init_done),
    .lookup_count(lookup_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] act;
    logic [3:0]  hops;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] ap;
    logic [1:0]  mode;
    logic [63:0] act;
    logic [3:0]  hops;
    logic        err;
    int          lat;
  } vec_t;

  localparam logic [63:0] E0A = 64'h0000_0000_0004_0001;
  localparam logic [63:0] E1A = 64'h0000_0F0F_0000_0002;
  localparam logic [63:0] E2A = 64'h0000_0100_0000_0010;
  localparam logic [95:0] CLR = {32'hFFFF_FFFF, 64'h0};

  exp_t exp_q[$];
  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [95:0] d);
    tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_data = d;
    tick();
    tbl_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [95:0] req, input string name);
    tbl_rd_en = 1'b1; tbl_rd_addr = a;
    tick();
    tbl_rd_en = 1'b0;
    check({name, "_vld"}, 128'(tbl_rd_valid), 128'(1'b1));
    check(name, 128'(tbl_rd_data), 128'(req));
  endtask

  task automatic push(input logic [63:0] a, input logic [3:0] h, input logic e);
    exp_t x;
    x.act = a; x.hops = h; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic collect(input string name);
    int   n = 0;
    exp_t x;
    logic [31:0] cnt;
    while (!result_valid && n < 100) begin tick(); n++; end
    if (!result_valid) begin
      check({name, "_timeout"}, 128'(result_valid), 128'(1'b1));
    end else if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 128'(exp_q.size()), 128'(1));
    end else begin
      x = exp_q.pop_front();
      check({name, "_action"}, 128'(result_action), 128'(x.act));
      check({name, "_hops"}, 128'(result_hops), 128'(x.hops));
      check({name, "_err"}, 128'(result_err), 128'(x.err));
      cnt = lookup_count;
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check({name, "_count"}, 128'(lookup_count), 128'(cnt + 32'd1));
    end
  endtask

  task automatic lookup(input logic [31:0] ap, input logic [1:0] mode, input logic [63:0] a,
                        input logic [3:0] h, input logic e, input int lat, input string name);
    int n = 0;
    while (!ap_in_ready && n < 50) begin tick(); n++; end
    check({name, "_ready"}, 128'(ap_in_ready), 128'(1'b1));
    ap_in = ap; merge_mode = mode; ap_in_valid = 1'b1;
    push(a, h, e);
    tick();
    ap_in_valid = 1'b0;
    n = 1;
    while (!result_valid && n < 100) begin tick(); n++; end
    check({name, "_latency"}, 128'(n), 128'(lat));
    collect(name);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 100) begin tick(); n++; end
    check(name, 128'(n), 128'(16));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] a0;
    logic [3:0]  h0;
    logic        e0;
    logic [31:0] cnt;
    int          n;

    vecs[0] = '{32'h0000_0000, 2'd0, E0A | E1A | E2A, 4'd3, 1'b0, 4};
    vecs[1] = '{32'h0000_0000, 2'd1, E2A,             4'd3, 1'b0, 4};
    vecs[2] = '{32'h0000_0000, 2'd2, E0A,             4'd3, 1'b0, 4};
    vecs[3] = '{32'h0000_0000, 2'd3, E0A | E1A | E2A, 4'd3, 1'b0, 4};
    vecs[4] = '{32'h0000_0001, 2'd0, E1A | E2A,       4'd2, 1'b0, 3};
    vecs[5] = '{32'h8000_0012, 2'd1, E2A,             4'd1, 1'b0, 2};
    vecs[6] = '{32'h0000_0010, 2'd0, E0A | E1A | E2A, 4'd3, 1'b0, 4};

    reset_n = 1'b0; ap_in = '0; ap_in_valid = 1'b0; merge_mode = '0; result_ready = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0; tbl_rd_en = 1'b0; tbl_rd_addr = '0;
    repeat (3) tick();
    check("rst_ready", 128'(ap_in_ready), 128'(0));
    check("rst_init", 128'(init_done), 128'(0));
    check("rst_rvalid", 128'(result_valid), 128'(0));
    check("rst_rdvalid", 128'(tbl_rd_valid), 128'(0));
    check("rst_counts", 128'({lookup_count, err_count}), 128'(0));
    reset_n = 1'b1;
    wait_init("init_latency");

    for (int a = 0; a < 16; a++) rd(4'(a), CLR, "clear_read");
    lookup(32'h8000_0003, 2'd0, 64'h0, 4'd1, 1'b0, 2, "single");

    wr(4'd0, {32'h0000_0001, E0A});
    wr(4'd1, {32'h8000_0002, E1A});
    wr(4'd2, {32'h1234_5678, E2A});
    for (int i = 0; i < 7; i++) lookup(vecs[i].ap, vecs[i].mode, vecs[i].act, vecs[i].hops,
                                       vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));

    wr(4'd0, {32'h0000_0001, 64'h0});
    lookup(32'h0, 2'd2, E1A, 4'd3, 1'b0, 4, "first_nz");

    // Self-loop without an end flag trips the hop guard.
    wr(4'd5, {32'h0000_0005, 64'hA0});
    lookup(32'h5, 2'd0, 64'hA0, 4'd8, 1'b1, 9, "loop");
    check("loop_errcnt", 128'(err_count), 128'(1));

    // Backpressure: result held, a second pointer waits with ap_in_valid high.
    push(E1A | E2A, 4'd3, 1'b0);
    push(E2A, 4'd1, 1'b0);
    ap_in = 32'h0; merge_mode = 2'd0; ap_in_valid = 1'b1;
    tick();
    ap_in = 32'h8000_0002;
    n = 0;
    while (!result_valid && n < 50) begin tick(); n++; end
    a0 = result_action; h0 = result_hops; e0 = result_err; cnt = lookup_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", 128'({result_valid, ap_in_ready, result_action, result_hops, result_err}),
            128'({1'b1, 1'b0, a0, h0, e0}));
    end
    check("stall_count", 128'(lookup_count), 128'(cnt));
    collect("stall_first");
    check("stall_idle_ready", 128'(ap_in_ready), 128'(1));
    tick();
    ap_in_valid = 1'b0;
    collect("stall_second");

    // Write e1 in the cycle it is visited: old data for this walk, new data afterwards.
    push(E1A | E2A, 4'd3, 1'b0);
    ap_in = 32'h0; merge_mode = 2'd0; ap_in_valid = 1'b1;
    tick();
    ap_in_valid = 1'b0;
    tick();
    wr(4'd1, {32'h8000_0002, 64'h55});
    collect("wr_walk_old");
    lookup(32'h0, 2'd0, 64'h55 | E2A, 4'd3, 1'b0, 4, "wr_walk_new");

    tbl_rd_en = 1'b1; tbl_rd_addr = 4'd7;
    tbl_wr_en = 1'b1; tbl_wr_addr = 4'd7; tbl_wr_data = {32'h8000_0000, 64'hBEEF};
    tick();
    tbl_rd_en = 1'b0; tbl_wr_en = 1'b0;
    check("rw_same_old", 128'(tbl_rd_data), 128'(CLR));
    rd(4'd7, {32'h8000_0000, 64'hBEEF}, "rw_same_new");

    // Reset mid-walk abandons the lookup and reruns CLEAR.
    ap_in = 32'h5; merge_mode = 2'd0; ap_in_valid = 1'b1;
    tick();
    ap_in_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", 128'({init_done, ap_in_ready, result_valid, result_err, result_hops, result_action}),
          128'(0));
    check("midrst_counts", 128'({lookup_count, err_count}), 128'(0));
    tick();
    reset_n = 1'b1;
    wait_init("midrst_init");
    check("midrst_no_result", 128'(result_valid), 128'(0));
    rd(4'd5, CLR, "midrst_cleared");
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
